// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the PS/2 lines, deframes
// 11-bit frames and holds the last good scan code for the IO decoder.
//
//   state    | meaning
//   S_IDLE   | waiting for a start bit (data 0 on a filtered clock fall)
//   S_DATA   | shifting in d0..d7, LSB first
//   S_PARITY | capturing the odd-parity bit
//   S_STOP   | checking the stop bit and publishing the byte or an error
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] io_data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_clk_filt;
  logic [7:0]            r_shift;
  logic [2:0]            r_bit_cnt;
  logic                  r_parity_ok;
  logic [TW-1:0]         r_to_cnt;

  logic w_sample;
  logic w_bit;
  logic w_start;
  logic w_shift_en;
  logic w_parity_en;
  logic w_load;
  logic w_perr;
  logic w_ferr;
  logic w_timeout;

  // Reset to all ones so releasing reset never looks like a clock fall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt      <= '1;
      r_clk_filt  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_filt      <= {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
      if (r_filt == '0)
        r_clk_filt <= 1'b0;
      else if (r_filt == '1)
        r_clk_filt <= 1'b1;
    end
  end

  assign w_sample = r_clk_filt && (r_filt == '0);
  assign w_bit    = r_data_sync[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_parity_en = 1'b0;
    w_load      = 1'b0;
    w_perr      = 1'b0;
    w_ferr      = 1'b0;
    // A sample event in the same cycle always beats the timeout.
    w_timeout   = (r_state != S_IDLE) && (r_to_cnt == TO_LAST) && !w_sample;
    case (r_state)
      S_IDLE: begin
        if (w_sample && !w_bit) begin
          w_start     = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7)
            w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_sample) begin
          w_parity_en = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_sample) begin
          w_state_nxt = S_IDLE;
          if (!w_bit)
            w_ferr = 1'b1;
          else if (r_parity_ok)
            w_load = 1'b1;
          else
            w_perr = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_ferr      = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_parity_ok <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_shift   <= 8'h00;
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_parity_en)
        r_parity_ok <= ^{r_shift, w_bit};
      if (w_sample || w_timeout || (r_state == S_IDLE))
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_data       <= 8'h00;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (w_load)
        io_data <= r_shift;
      data_valid    <= w_load;
      parity_error  <= w_perr;
      framing_error <= w_ferr;
    end
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver that deserialises device-to-host frames into 8-bit scan codes. It drives the `IODataIn[7:0]` byte consumed by the memory-mapped IO decoder. The CPU reads that byte as two nibbles at addresses 65533 (high) and 65534 (low). The block synchronises and glitch-filters the external PS/2 lines, checks framing and odd parity, and holds the last good scan code until the next one arrives.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised `ps2_clk` samples required before the filtered clock changes level.
- `TIMEOUT_CYCLES`, default 50000: system clocks allowed between sample events inside a frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- `clock`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock from connector, asynchronous.
- `ps2_data`  input  1  raw PS/2 data from connector, asynchronous.
- `io_data`  output  8  last good scan code; feeds `IODataIn`.
- `data_valid`  output  1  one-cycle pulse when `io_data` is updated.
- `parity_error`  output  1  one-cycle pulse on a parity-failed frame.
- `framing_error`  output  1  one-cycle pulse on bad stop bit or timeout.

## Operation
- **Synchronisers:** two-flop synchroniser on each of `ps2_clk` and `ps2_data`.
- **Glitch filter:** shift register of `FILTER_LEN` synchronised clock samples.
  - Filtered clock goes 0 when all samples are 0.
  - Filtered clock goes 1 when all samples are 1.
  - Otherwise it holds its level.
- **Sample event:** a cycle in which the filtered clock goes 1→0. The bit taken is the synchronised `ps2_data` in that cycle.
- **Frame format:** 11 bits, LSB first: start(0), d0..d7, parity (odd over d0..d7 plus the parity bit), stop(1).
- **FSM states:**
  - IDLE:
    - Sample event with data 0 → DATA, bit counter = 0.
    - Sample event with data 1 is ignored; stay in IDLE, no error.
  - DATA:
    - Each sample event shifts the bit into a shift register at the MSB and shifts right, so d0 ends at bit 0. Counter increments.
    - After the 8th bit (counter 7) → PARITY.
  - PARITY:
    - Sample event: parity_ok = XOR(d0..d7, p) == 1. → STOP.
  - STOP, on a sample event:
    - Data 1 and parity_ok: `io_data` ← shift register, pulse `data_valid`.
    - Data 1 and not parity_ok: pulse `parity_error`; `io_data` is unchanged.
    - Data 0: pulse `framing_error` only (framing takes priority over parity); `io_data` is unchanged.
    - Always → IDLE.
- **Timeout:** the counter clears on every sample event and counts in every state except IDLE.
  - When it reaches `TIMEOUT_CYCLES-1` the FSM aborts to IDLE, pulses `framing_error`, and the partial byte is discarded.
  - A timeout and a sample event in the same cycle: the sample event wins.
- Only one of the three pulses is ever high in a given cycle.
- `io_data` changes only on a good frame. The IO decoder may read it at any time.

## Timing
- **Reset (asynchronous, `reset`=0):**
  - State IDLE; `io_data` = 8'h00.
  - `data_valid`, `parity_error`, `framing_error` = 0.
  - Synchronisers and filter register = all 1; filtered clock = 1, so no false edge on release.
  - Bit and timeout counters = 0.
- Reset asserted mid-frame aborts the frame with no error pulse.
- **Edge latency:** a sample event occurs 2 + `FILTER_LEN` clocks after a clean raw `ps2_clk` fall. Data is sampled 2 clocks after the raw value; PS/2 data is stable for the entire low phase.
- **Output latency:** `io_data`, `data_valid` and the error flags are registered and update on the clock edge ending the stop-bit sample-event cycle.
  - All three pulses are exactly one clock wide.
  - The new `io_data` is visible in the same cycle as the `data_valid` pulse.
- Back-to-back frames need no idle gap beyond the PS/2 stop-to-start spacing. The FSM re-arms in IDLE the cycle after STOP.
- `ps2_clk` low pulses shorter than `FILTER_LEN` clocks never produce a sample event.

## Test plan
Bench conditions: `FILTER_LEN`=8, `TIMEOUT_CYCLES`=1000, PS/2 half-period 200 clocks.

- **Good frame 0x1C, parity 0:** `io_data`=0x1C, `data_valid` high exactly 1 cycle, no error pulses.
- **Frames 0xF0 (p=1), then 0x1C (p=0):** two `data_valid` pulses; `io_data` 0xF0 then 0x1C.
- **Frame 0x1C with p=1, after a good 0x5A (p=1):** `parity_error` pulse; `io_data` stays 0x5A; no `data_valid`.
- **Frame 0x29 (p=0) with stop=0:** `framing_error` pulse; `io_data` unchanged.
- **Glitch, then timeout, then recovery:**
  - 5-clock `ps2_clk` low glitch in IDLE with data 0 → no state change, no pulses.
  - Then 4 data bits followed by a held-high clock → `framing_error` 1000 clocks after the last sample event.
  - Then a full 0x5A frame → `io_data`=0x5A.
- **Reset mid-frame:** assert `reset` low after 5 bits → all outputs 0 immediately (asynchronous). Release, send 0x29 (p=0) → `io_data`=0x29, single `data_valid`.
